// File: rtl/icache_miss_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : icache_miss_scheduler
// Brief    : Per-thread L1I miss tracker. Merges duplicate lines, issues L2
//            fill requests round-robin and pulses a per-thread fetch wakeup.
// Revision : 1.0 - initial release
// ============================================================================
module icache_miss_scheduler #(
    parameter int NUM_THREADS     = 4,
    parameter int LINE_ADDR_WIDTH = 26
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           miss_en,
    input  logic [$clog2(NUM_THREADS)-1:0] miss_thread_idx,
    input  logic [LINE_ADDR_WIDTH-1:0]     miss_line_addr,
    input  logic                           flush_en,
    output logic                           l2_req_valid,
    input  logic                           l2_req_ready,
    output logic [LINE_ADDR_WIDTH-1:0]     l2_req_line_addr,
    output logic [$clog2(NUM_THREADS)-1:0] l2_req_thread_idx,
    input  logic                           l2_resp_valid,
    input  logic [LINE_ADDR_WIDTH-1:0]     l2_resp_line_addr,
    output logic [NUM_THREADS-1:0]         wakeup_mask,
    output logic [NUM_THREADS-1:0]         pending_mask
);

    localparam int c_idx_w = $clog2(NUM_THREADS);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ISSUED  = 2'd2
    } entry_state_t;

    entry_state_t               r_state     [NUM_THREADS];
    logic [LINE_ADDR_WIDTH-1:0] r_addr      [NUM_THREADS];
    logic                       r_req_valid;
    logic [LINE_ADDR_WIDTH-1:0] r_req_addr;
    logic [c_idx_w-1:0]         r_req_idx;
    logic [c_idx_w-1:0]         r_rr_ptr;
    logic [NUM_THREADS-1:0]     r_wakeup;
    logic [NUM_THREADS-1:0]     r_pending;

    entry_state_t               w_state_nxt [NUM_THREADS];
    logic [LINE_ADDR_WIDTH-1:0] w_addr_nxt  [NUM_THREADS];
    logic                       w_req_valid_nxt;
    logic [LINE_ADDR_WIDTH-1:0] w_req_addr_nxt;
    logic [c_idx_w-1:0]         w_req_idx_nxt;
    logic [c_idx_w-1:0]         w_rr_ptr_nxt;
    logic [NUM_THREADS-1:0]     w_wakeup_nxt;
    logic [NUM_THREADS-1:0]     w_pending_nxt;

    logic [NUM_THREADS-1:0]     w_issued_dup;
    logic [NUM_THREADS-1:0]     w_elig;
    logic                       w_grant_valid;
    logic [c_idx_w-1:0]         w_grant_idx;
    logic                       w_accept;
    logic                       w_slot_open;

    // A pending line is held back while the same line is already in flight,
    // sits in the request register, or is being filled this very cycle.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_issued_dup[t] = 1'b0;
            for (int j = 0; j < NUM_THREADS; j++) begin
                if (r_state[j] == ST_ISSUED && r_addr[j] == r_addr[t]) begin
                    w_issued_dup[t] = 1'b1;
                end
            end
            w_elig[t] = (r_state[t] == ST_PENDING) && !w_issued_dup[t]
                     && !(r_req_valid && r_req_addr == r_addr[t])
                     && !(l2_resp_valid && l2_resp_line_addr == r_addr[t]);
        end
    end

    // Round-robin search starting at r_rr_ptr (one past the last grant).
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (!w_grant_valid && w_elig[r_rr_ptr + c_idx_w'(i)]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = r_rr_ptr + c_idx_w'(i);
            end
        end
    end

    assign w_accept    = r_req_valid && l2_req_ready;
    assign w_slot_open = !r_req_valid || w_accept;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_req_valid_nxt = r_req_valid;
        w_req_addr_nxt  = r_req_addr;
        w_req_idx_nxt   = r_req_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_wakeup_nxt    = '0;

        if (w_accept) begin
            w_state_nxt[r_req_idx] = ST_ISSUED;
        end

        if (w_slot_open) begin
            w_req_valid_nxt = w_grant_valid;
            if (w_grant_valid) begin
                w_req_addr_nxt = r_addr[w_grant_idx];
                w_req_idx_nxt  = w_grant_idx;
                w_rr_ptr_nxt   = w_grant_idx + c_idx_w'(1);
            end
        end else if (l2_resp_valid && r_req_addr == l2_resp_line_addr) begin
            w_req_valid_nxt = 1'b0;
        end

        // The fill releases every waiter on the line, including entries that
        // only just got accepted above.
        if (l2_resp_valid) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (r_state[t] != ST_FREE && r_addr[t] == l2_resp_line_addr) begin
                    w_state_nxt[t]  = ST_FREE;
                    w_wakeup_nxt[t] = 1'b1;
                end
            end
        end

        if (miss_en && r_state[miss_thread_idx] == ST_FREE) begin
            if (l2_resp_valid && miss_line_addr == l2_resp_line_addr) begin
                w_wakeup_nxt[miss_thread_idx] = 1'b1;
            end else begin
                w_state_nxt[miss_thread_idx] = ST_PENDING;
                w_addr_nxt[miss_thread_idx]  = miss_line_addr;
            end
        end

        if (flush_en) begin
            w_req_valid_nxt = 1'b0;
            w_rr_ptr_nxt    = r_rr_ptr;
            for (int t = 0; t < NUM_THREADS; t++) begin
                w_wakeup_nxt[t] = (r_state[t] != ST_FREE);
                w_state_nxt[t]  = ST_FREE;
            end
        end

        for (int t = 0; t < NUM_THREADS; t++) begin
            w_pending_nxt[t] = (w_state_nxt[t] != ST_FREE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_state[t] <= ST_FREE;
                r_addr[t]  <= '0;
            end
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_idx   <= '0;
            r_rr_ptr    <= '0;
            r_wakeup    <= '0;
            r_pending   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_req_idx   <= w_req_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_wakeup    <= w_wakeup_nxt;
            r_pending   <= w_pending_nxt;
        end
    end

    assign l2_req_valid      = r_req_valid;
    assign l2_req_line_addr  = r_req_addr;
    assign l2_req_thread_idx = r_req_idx;
    assign wakeup_mask       = r_wakeup;
    assign pending_mask      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_icache_miss_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_miss_scheduler
// Brief    : Directed self-checking bench for icache_miss_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_miss_scheduler;

    localparam int NUM_THREADS     = 4;
    localparam int LINE_ADDR_WIDTH = 26;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       miss_en = 1'b0;
    logic [1:0]                 miss_thread_idx = '0;
    logic [LINE_ADDR_WIDTH-1:0] miss_line_addr = '0;
    logic                       flush_en = 1'b0;
    logic                       l2_req_valid;
    logic                       l2_req_ready = 1'b0;
    logic [LINE_ADDR_WIDTH-1:0] l2_req_line_addr;
    logic [1:0]                 l2_req_thread_idx;
    logic                       l2_resp_valid = 1'b0;
    logic [LINE_ADDR_WIDTH-1:0] l2_resp_line_addr = '0;
    logic [NUM_THREADS-1:0]     wakeup_mask;
    logic [NUM_THREADS-1:0]     pending_mask;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int acc0;

    icache_miss_scheduler #(
        .NUM_THREADS     (NUM_THREADS),
        .LINE_ADDR_WIDTH (LINE_ADDR_WIDTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .miss_en           (miss_en),
        .miss_thread_idx   (miss_thread_idx),
        .miss_line_addr    (miss_line_addr),
        .flush_en          (flush_en),
        .l2_req_valid      (l2_req_valid),
        .l2_req_ready      (l2_req_ready),
        .l2_req_line_addr  (l2_req_line_addr),
        .l2_req_thread_idx (l2_req_thread_idx),
        .l2_resp_valid     (l2_resp_valid),
        .l2_resp_line_addr (l2_resp_line_addr),
        .wakeup_mask       (wakeup_mask),
        .pending_mask      (pending_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (l2_req_valid && l2_req_ready) n_acc++;
    end

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input int t, input int addr);
        miss_en         = 1'b1;
        miss_thread_idx = 2'(t);
        miss_line_addr  = LINE_ADDR_WIDTH'(addr);
    endtask

    task automatic resp(input int addr);
        l2_resp_valid     = 1'b1;
        l2_resp_line_addr = LINE_ADDR_WIDTH'(addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset takes effect before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk_value("rst_valid", l2_req_valid, 0);
        chk_value("rst_wakeup", wakeup_mask, 0);
        chk_value("rst_pending", pending_mask, 0);
        chk_value("rst_addr", l2_req_line_addr, 0);
        chk_value("rst_idx", l2_req_thread_idx, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single miss: request at N+2, wakeup after response.
        l2_req_ready = 1'b1;
        miss(1, 'h40);
        tick(); miss_en = 1'b0;
        chk_value("t1_pend_c1", pending_mask, 4'b0010);
        chk_value("t1_valid_c1", l2_req_valid, 0);
        tick();
        chk_value("t1_valid_c2", l2_req_valid, 1);
        chk_value("t1_addr_c2", l2_req_line_addr, 'h40);
        chk_value("t1_idx_c2", l2_req_thread_idx, 1);
        tick();
        chk_value("t1_valid_c3", l2_req_valid, 0);
        chk_value("t1_pend_c3", pending_mask, 4'b0010);
        repeat (3) tick();
        resp('h40);
        tick(); l2_resp_valid = 1'b0;
        chk_value("t1_wake", wakeup_mask, 4'b0010);
        chk_value("t1_pend_end", pending_mask, 4'b0000);
        tick();
        chk_value("t1_wake_pulse", wakeup_mask, 4'b0000);

        // Duplicate line from two threads: one request, shared wakeup.
        acc0 = n_acc;
        miss(0, 'h80);
        tick(); miss(2, 'h80);
        tick(); miss_en = 1'b0;
        chk_value("t2_valid", l2_req_valid, 1);
        chk_value("t2_idx", l2_req_thread_idx, 0);
        chk_value("t2_addr", l2_req_line_addr, 'h80);
        repeat (4) tick();
        chk_value("t2_nreq", n_acc - acc0, 1);
        chk_value("t2_valid_after", l2_req_valid, 0);
        chk_value("t2_pend", pending_mask, 4'b0101);
        resp('h80);
        tick(); l2_resp_valid = 1'b0;
        chk_value("t2_wake", wakeup_mask, 4'b0101);
        chk_value("t2_pend_end", pending_mask, 4'b0000);

        // Miss coincident with the fill of the same line.
        miss(3, 'h100);
        resp('h100);
        tick(); miss_en = 1'b0; l2_resp_valid = 1'b0;
        chk_value("t3_wake", wakeup_mask, 4'b1000);
        chk_value("t3_pend", pending_mask, 4'b0000);
        chk_value("t3_valid_c1", l2_req_valid, 0);
        tick();
        chk_value("t3_valid_c2", l2_req_valid, 0);

        // Back-pressure, then round-robin drain on consecutive cycles.
        l2_req_ready = 1'b0;
        miss(0, 'h200);
        tick(); miss(1, 'h210);
        tick(); miss(2, 'h220);
        chk_value("t4_valid_c2", l2_req_valid, 1);
        chk_value("t4_addr_c2", l2_req_line_addr, 'h200);
        tick(); miss(3, 'h230);
        tick(); miss_en = 1'b0;
        for (int c = 4; c < 7; c++) begin
            chk_value($sformatf("t4_stall_valid_c%0d", c), l2_req_valid, 1);
            chk_value($sformatf("t4_stall_addr_c%0d", c), l2_req_line_addr, 'h200);
            chk_value($sformatf("t4_stall_idx_c%0d", c), l2_req_thread_idx, 0);
            if (c < 6) tick();
        end
        chk_value("t4_pend_full", pending_mask, 4'b1111);
        l2_req_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_value($sformatf("t4_rr_valid_%0d", i), l2_req_valid, 1);
            chk_value($sformatf("t4_rr_idx_%0d", i), l2_req_thread_idx, i);
            chk_value($sformatf("t4_rr_addr_%0d", i), l2_req_line_addr, 'h200 + 16 * i);
        end
        tick();
        chk_value("t4_drained", l2_req_valid, 0);
        for (int i = 0; i < 4; i++) begin
            resp('h200 + 16 * i);
            tick();
            chk_value($sformatf("t4_wake_%0d", i), wakeup_mask, 1 << i);
        end
        l2_resp_valid = 1'b0;
        chk_value("t4_pend_end", pending_mask, 4'b0000);

        // Flush of two in-flight misses; stale fills wake nobody.
        miss(0, 'h300);
        tick(); miss(1, 'h310);
        tick(); miss_en = 1'b0;
        repeat (3) tick();
        chk_value("t5_pend", pending_mask, 4'b0011);
        chk_value("t5_valid", l2_req_valid, 0);
        miss(0, 'h3f0);
        tick(); miss_en = 1'b0;
        tick();
        chk_value("t5_ignored_miss", l2_req_valid, 0);
        chk_value("t5_pend_kept", pending_mask, 4'b0011);
        flush_en = 1'b1;
        tick(); flush_en = 1'b0;
        chk_value("t5_flush_pend", pending_mask, 4'b0000);
        chk_value("t5_flush_wake", wakeup_mask, 4'b0011);
        chk_value("t5_flush_valid", l2_req_valid, 0);
        resp('h300);
        tick();
        chk_value("t5_stale_wake0", wakeup_mask, 4'b0000);
        resp('h310);
        tick(); l2_resp_valid = 1'b0;
        chk_value("t5_stale_wake1", wakeup_mask, 4'b0000);

        // Fill for the queued line clears the request register unaccepted.
        l2_req_ready = 1'b0;
        miss(1, 'h500);
        tick(); miss_en = 1'b0;
        tick();
        chk_value("t6_valid", l2_req_valid, 1);
        chk_value("t6_idx", l2_req_thread_idx, 1);
        resp('h500);
        tick(); l2_resp_valid = 1'b0;
        chk_value("t6_cleared", l2_req_valid, 0);
        chk_value("t6_wake", wakeup_mask, 4'b0010);
        chk_value("t6_pend", pending_mask, 4'b0000);

        // Asynchronous reset in the middle of a stalled request.
        miss(2, 'h400);
        tick(); miss_en = 1'b0;
        tick();
        chk_value("t7_valid", l2_req_valid, 1);
        chk_value("t7_idx", l2_req_thread_idx, 2);
        #3 reset = 1'b1;
        #1;
        chk_value("t7_async_valid", l2_req_valid, 0);
        chk_value("t7_async_pend", pending_mask, 4'b0000);
        tick(); tick();
        reset = 1'b0;
        resp('h400);
        tick(); l2_resp_valid = 1'b0;
        chk_value("t7_no_wake", wakeup_mask, 4'b0000);
        chk_value("t7_post_valid", l2_req_valid, 0);
        tick();
        chk_value("t7_post_valid2", l2_req_valid, 0);
        chk_value("t7_post_pend", pending_mask, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
